conv_result_streamer: RTL and testbench

//  Downstream drain stage for the convolution coprocessor output memory (Z memory).
//  On a start pulse (the core's done), it reads len_i words from the Z memory, addresses 0..len_i-1.

---
 rtl/conv_pkg.sv | 16 +
 rtl/conv_stream_skid_fifo.sv | 70 +++++++
 rtl/conv_result_streamer.sv | 150 +++++++++++++++
 tb/tb_conv_result_streamer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution coprocessor output path.
// Provides default memory geometry and the drain FSM state encoding.
package conv_pkg;

  localparam int unsigned CONV_DATA_WIDTH = 32;
  localparam int unsigned CONV_ADDR_WIDTH = 6;

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_STREAM = 1'b1;

  typedef enum logic {
    StIdle   = ST_IDLE,
    StStream = ST_STREAM
  } stream_state_e;

endpackage

// File: rtl/conv_stream_skid_fifo.sv
// Two-entry register FIFO that absorbs the memory read latency in front of the
// output stream.
// Ports:
//   clk, rstn      clock, synchronous active-low reset
//   flush_i        drop all contents (priority over push/pop)
//   push_i         write push_data_i
//   pop_i          discard the head entry
//   head_o         oldest entry
//   count_o        occupancy 0..2
//   empty_o        no entries
//   full_o         two entries
module conv_stream_skid_fifo #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic [1:0]            count_o,
  output logic                  empty_o,
  output logic                  full_o
);

  logic [DATA_WIDTH-1:0] data_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q;
  logic                  do_push;
  logic                  do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  // A full FIFO can still accept a write when the head leaves in the same cycle.
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        data_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = data_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == 2'd2);

endmodule

// File: rtl/conv_result_streamer.sv
// Drains the Z memory onto a valid/ready stream after the core finishes.
// On an accepted start it reads words 0..len-1 and emits them in order with a
// last marker, sustaining one word per cycle despite the 1-cycle read latency.
// Ports:
//   clk, rstn                 clock, synchronous active-low reset
//   start_i, len_i, abort_i   control: begin transfer of len_i words / cancel
//   busy_o, done_o            status: streaming / normal completion pulse
//   start_drop_o              sticky flag: a start arrived while busy
//   mem_rd_*                  Z memory read port (data one cycle after enable)
//   m_data_o/m_valid_o/m_last_o/m_ready_i   output stream
module conv_result_streamer
  import conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = CONV_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = CONV_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  start_drop_o,
  output logic                  mem_rd_en_o,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  output logic                  m_last_o,
  input  logic                  m_ready_i
);

  localparam int unsigned CntW = ADDR_WIDTH + 1;
  localparam logic [CntW-1:0] MaxLen = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [CntW-1:0] One    = {{ADDR_WIDTH{1'b0}}, 1'b1};

  stream_state_e         state_q;
  logic [CntW-1:0]       len_q;
  logic [CntW-1:0]       rd_cnt_q;
  logic [CntW-1:0]       beat_cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  inflight_q;
  logic                  done_q;
  logic                  drop_q;

  logic [1:0]            fifo_count;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  handshake;
  logic [2:0]            occupancy;
  logic                  rd_issue;
  logic [CntW-1:0]       len_clamped;

  assign len_clamped = (len_i > MaxLen) ? MaxLen : len_i;

  assign m_valid_o = !fifo_empty;
  assign m_data_o  = fifo_head;
  assign handshake = m_valid_o && m_ready_i;
  assign m_last_o  = m_valid_o && (beat_cnt_q == len_q - One);

  // Words held or in flight after this cycle's pop; the slot freed by a pop
  // can be re-requested immediately, which is what keeps the stream gapless.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, handshake};

  assign rd_issue = (state_q == StStream) && (rd_cnt_q < len_q) && (occupancy < 3'd2)
                    && !(fifo_full && !handshake);

  assign mem_rd_en_o   = rd_issue;
  assign mem_rd_addr_o = rd_issue ? rd_cnt_q[ADDR_WIDTH-1:0] : addr_q;

  assign busy_o       = (state_q == StStream);
  assign done_o       = done_q;
  assign start_drop_o = drop_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= StIdle;
      len_q      <= '0;
      rd_cnt_q   <= '0;
      beat_cnt_q <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= rd_issue;
      if (rd_issue) begin
        rd_cnt_q <= rd_cnt_q + One;
        addr_q   <= rd_cnt_q[ADDR_WIDTH-1:0];
      end
      if (handshake) begin
        beat_cnt_q <= beat_cnt_q + One;
      end
      if (abort_i) begin
        // A read issued this cycle returns into a discarded slot.
        state_q    <= StIdle;
        rd_cnt_q   <= '0;
        beat_cnt_q <= '0;
        inflight_q <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (start_i) begin
              drop_q     <= 1'b0;
              rd_cnt_q   <= '0;
              beat_cnt_q <= '0;
              if (len_i == '0) begin
                done_q <= 1'b1;
              end else begin
                state_q <= StStream;
                len_q   <= len_clamped;
              end
            end
          end
          StStream: begin
            if (start_i) begin
              drop_q <= 1'b1;
            end
            if (handshake && m_last_o) begin
              state_q    <= StIdle;
              done_q     <= 1'b1;
              rd_cnt_q   <= '0;
              beat_cnt_q <= '0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  conv_stream_skid_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .flush_i    (abort_i),
    .push_i     (inflight_q),
    .push_data_i(mem_rd_data_i),
    .pop_i      (handshake),
    .head_o     (fifo_head),
    .count_o    (fifo_count),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full)
  );

endmodule

// File: tb/tb_conv_result_streamer.sv
module tb_conv_result_streamer;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int MAXW = 64;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  logic          clk;
  logic          rstn;
  logic          start_i;
  logic [AW:0]   len_i;
  logic          abort_i;
  logic          busy_o;
  logic          done_o;
  logic          start_drop_o;
  logic          mem_rd_en_o;
  logic [AW-1:0] mem_rd_addr_o;
  logic [DW-1:0] mem_rd_data_i;
  logic [DW-1:0] m_data_o;
  logic          m_valid_o;
  logic          m_last_o;
  logic          m_ready_i;

  logic [DW-1:0] zmem [MAXW];
  beat_t         exp_q [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: driven by scenario
  int reads, beats, cur_len, t_start;
  int first_rd_cyc, first_valid_cyc, last_hs_cyc, done_cyc;
  int done_cnt = 0;
  logic [DW-1:0] first_data, last_data;
  logic          stall_q = 1'b0;
  logic [DW-1:0] stall_data;
  logic          stall_last;

  conv_result_streamer #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .start_i      (start_i),
    .len_i        (len_i),
    .abort_i      (abort_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .start_drop_o (start_drop_o),
    .mem_rd_en_o  (mem_rd_en_o),
    .mem_rd_addr_o(mem_rd_addr_o),
    .mem_rd_data_i(mem_rd_data_i),
    .m_data_o     (m_data_o),
    .m_valid_o    (m_valid_o),
    .m_last_o     (m_last_o),
    .m_ready_i    (m_ready_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Z memory: synchronous read, one cycle latency.
  always @(posedge clk) begin
    if (mem_rd_en_o) mem_rd_data_i <= zmem[mem_rd_addr_o];
  end

  initial begin
    m_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_ready_i = 1'b1;
        1:       m_ready_i = 1'($urandom_range(0, 1));
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Stream/read monitor compared against the expected-beat queue every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn) begin
        int hs;
        hs = (m_valid_o && m_ready_i) ? 1 : 0;
        if (stall_q) begin
          chk("stall_valid", m_valid_o, 1);
          chk("stall_data", m_data_o, stall_data);
          chk("stall_last", m_last_o, stall_last);
        end
        if (mem_rd_en_o) begin
          if (first_rd_cyc < 0) first_rd_cyc = cyc;
          chk("rd_addr", mem_rd_addr_o, reads);
          chk("rd_within_len", reads < cur_len, 1);
          chk("rd_credit", (reads - beats - hs) < 2, 1);
          reads++;
        end
        if (m_valid_o) begin
          if (first_valid_cyc < 0) first_valid_cyc = cyc;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got data %0h, required no beat (cycle %0d)",
                     m_data_o, cyc);
          end else begin
            chk("beat_data", m_data_o, exp_q[0].d);
            chk("beat_last", m_last_o, exp_q[0].l);
            if (hs != 0) begin
              if (beats == 0) first_data = m_data_o;
              if (m_last_o) last_data = m_data_o;
              void'(exp_q.pop_front());
              beats++;
              last_hs_cyc = cyc;
            end
          end
        end
        if (done_o) begin
          done_cnt++;
          done_cyc = cyc;
          chk("busy_at_done", busy_o, 0);
        end
        stall_q    = m_valid_o && !m_ready_i;
        stall_data = m_data_o;
        stall_last = m_last_o;
      end else begin
        stall_q = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_xfer(input int n);
    reads = 0;
    beats = 0;
    cur_len = n;
    first_rd_cyc = -1;
    first_valid_cyc = -1;
    last_hs_cyc = -1;
    first_data = '0;
    last_data = '0;
  endtask

  task automatic do_start(input int len);
    int n;
    n = (len > MAXW) ? MAXW : len;
    start_i = 1'b1;
    len_i = 7'(len);
    t_start = cyc;
    clear_xfer(n);
    for (int i = 0; i < n; i++) exp_q.push_back('{zmem[i], (i == n - 1)});
    step();
    start_i = 1'b0;
  endtask

  task automatic ignored_start(input int len);
    start_i = 1'b1;
    len_i = 7'(len);
    step();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n0;
    int k;
    n0 = done_cnt;
    k = 0;
    while (done_cnt == n0 && k < budget) begin
      step();
      k++;
    end
    chk({name, "_done_pulse"}, done_cnt - n0, 1);
  endtask

  initial begin
    int n0;
    rstn = 1'b0;
    start_i = 1'b0;
    abort_i = 1'b0;
    len_i = '0;
    for (int i = 0; i < MAXW; i++) zmem[i] = 32'h100 + i;
    clear_xfer(0);
    repeat (3) step();
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_drop", start_drop_o, 0);
    chk("rst_rd_en", mem_rd_en_o, 0);
    chk("rst_rd_addr", mem_rd_addr_o, 0);
    chk("rst_valid", m_valid_o, 0);
    chk("rst_last", m_last_o, 0);
    chk("rst_data", m_data_o, 0);
    rstn = 1'b1;
    step();

    // 1: len=5, continuous ready
    do_start(5);
    wait_done("t1", 50);
    chk("t1_first_rd", first_rd_cyc, t_start + 1);
    chk("t1_first_valid", first_valid_cyc, t_start + 3);
    chk("t1_gapless", last_hs_cyc - first_valid_cyc, 4);
    chk("t1_done_after_last", done_cyc, last_hs_cyc + 1);
    chk("t1_reads", reads, 5);
    chk("t1_beats", beats, 5);
    chk("t1_first_data", first_data, 32'h100);
    chk("t1_last_data", last_data, 32'h104);
    step();

    // 2: len=6, random backpressure
    for (int i = 0; i < MAXW; i++) zmem[i] = $urandom;
    rdy_mode = 1;
    do_start(6);
    wait_done("t2", 200);
    chk("t2_beats", beats, 6);
    chk("t2_reads", reads, 6);
    chk("t2_queue_empty", exp_q.size(), 0);
    rdy_mode = 0;
    step();

    // 3: len=0
    do_start(0);
    chk("t3_busy", busy_o, 0);
    wait_done("t3", 5);
    chk("t3_done_cyc", done_cyc, t_start + 1);
    chk("t3_reads", reads, 0);
    chk("t3_no_valid", first_valid_cyc, -1);
    step();

    // 4: maximum length, then over-length clamp
    for (int i = 0; i < MAXW; i++) zmem[i] = i;
    do_start(64);
    wait_done("t4a", 200);
    chk("t4a_beats", beats, 64);
    chk("t4a_last_data", last_data, 63);
    do_start(100);
    wait_done("t4b", 200);
    chk("t4b_beats", beats, 64);
    chk("t4b_reads", reads, 64);
    rdy_mode = 1;
    do_start(127);
    wait_done("t4c", 400);
    chk("t4c_beats", beats, 64);
    rdy_mode = 0;
    step();

    // 5: start while busy
    for (int i = 0; i < MAXW; i++) zmem[i] = $urandom;
    do_start(8);
    step();
    ignored_start(3);
    chk("t5_drop_set", start_drop_o, 1);
    wait_done("t5", 100);
    chk("t5_beats", beats, 8);
    chk("t5_drop_held", start_drop_o, 1);
    do_start(1);
    chk("t5_drop_cleared", start_drop_o, 0);
    wait_done("t5b", 20);
    chk("t5b_beats", beats, 1);

    // reset mid-transfer clears everything including the drop flag
    do_start(8);
    step();
    ignored_start(2);
    n0 = done_cnt;
    rstn = 1'b0;
    step();
    exp_q.delete();
    chk("mrst_busy", busy_o, 0);
    chk("mrst_drop", start_drop_o, 0);
    chk("mrst_valid", m_valid_o, 0);
    rstn = 1'b1;
    repeat (4) step();
    chk("mrst_no_done", done_cnt - n0, 0);

    // 6: abort with full FIFO and stalled stream
    rdy_mode = 2;
    m_ready_i = 1'b1;
    do_start(10);
    for (int k = 0; k < 50 && beats < 3; k++) step();
    m_ready_i = 1'b0;
    repeat (4) step();
    chk("t6_beats_before", beats, 3);
    chk("t6_valid_stalled", m_valid_o, 1);
    n0 = done_cnt;
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    exp_q.delete();
    stall_q = 1'b0;
    chk("t6_valid_after", m_valid_o, 0);
    chk("t6_busy_after", busy_o, 0);
    m_ready_i = 1'b1;
    repeat (5) step();
    chk("t6_no_done", done_cnt - n0, 0);
    rdy_mode = 0;
    do_start(2);
    wait_done("t6b", 20);
    chk("t6b_beats", beats, 2);
    chk("t6b_first", first_data, zmem[0]);
    chk("t6b_last", last_data, zmem[1]);
    repeat (3) step();
    chk("end_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
